// File: rtl/hamming_scan_engine_if.sv
// Byte-wide data_mem port: engine drives address and write strobe/data, memory returns read data
// combinationally from the address in the same cycle.
interface hamming_scan_engine_if;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;

    modport master (
        output mem_addr,
        output mem_wr_en,
        output mem_wr_data,
        input  mem_rd_data
    );

    modport slave (
        input  mem_addr,
        input  mem_wr_en,
        input  mem_wr_data,
        output mem_rd_data
    );
endinterface

// File: rtl/hamming_scan_engine.sv
// Min/max pairwise Hamming distance over NUM_WORDS 16-bit operands: 2N load cycles, N(N-1)/2 compare
// cycles, two result writes, then done held until reset. Sole memory master, no backpressure.
module hamming_scan_engine #(
    parameter int NUM_WORDS   = 32,
    parameter int BASE_ADDR   = 0,
    parameter int RESULT_ADDR = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    hamming_scan_engine_if.master        mem,
    output logic                         done,
    output logic [4:0]                   min_dist,
    output logic [4:0]                   max_dist,
    output logic [4:0]                   min_idx_a,
    output logic [4:0]                   min_idx_b,
    output logic [4:0]                   max_idx_a,
    output logic [4:0]                   max_idx_b
);

    typedef enum logic [2:0] {
        S_LOAD,
        S_COMPARE,
        S_WR_MIN,
        S_WR_MAX,
        S_DONE
    } state_t;

    localparam logic [6:0] LAST_BYTE = 7'(2 * NUM_WORDS - 1);
    localparam logic [4:0] LAST_J    = 5'(NUM_WORDS - 2);
    localparam logic [4:0] LAST_K    = 5'(NUM_WORDS - 1);
    localparam logic [7:0] BASE_A    = 8'(BASE_ADDR);
    localparam logic [7:0] RES_A     = 8'(RESULT_ADDR);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [6:0]  r_cnt;
    logic [4:0]  r_j;
    logic [4:0]  r_k;
    logic [4:0]  r_min;
    logic [4:0]  r_max;
    logic [4:0]  r_min_a;
    logic [4:0]  r_min_b;
    logic [4:0]  r_max_a;
    logic [4:0]  r_max_b;
    logic [15:0] r_words [0:31];
    logic [4:0]  w_dist;
    logic        w_load_last;
    logic        w_cmp_last;

    function automatic logic [4:0] popcnt16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int b = 0; b < 16; b++) begin
            c = c + 5'(v[b]);
        end
        return c;
    endfunction

    assign w_dist      = popcnt16(r_words[r_j] ^ r_words[r_k]);
    assign w_load_last = (r_cnt == LAST_BYTE);
    assign w_cmp_last  = (r_j == LAST_J) && (r_k == LAST_K);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Memory port is a pure function of state so reset immediately restores the idle values;
    // the write strobe is also gated by reset so an aborted run never writes.
    always_comb begin
        w_state_nxt     = r_state;
        mem.mem_addr    = BASE_A + {1'b0, r_cnt};
        mem.mem_wr_en   = 1'b0;
        mem.mem_wr_data = 8'h00;
        done            = 1'b0;
        case (r_state)
            S_LOAD: begin
                if (w_load_last) begin
                    w_state_nxt = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (w_cmp_last) begin
                    w_state_nxt = S_WR_MIN;
                end
            end
            S_WR_MIN: begin
                mem.mem_addr    = RES_A;
                mem.mem_wr_en   = !reset;
                mem.mem_wr_data = {3'b000, r_min};
                w_state_nxt     = S_WR_MAX;
            end
            S_WR_MAX: begin
                mem.mem_addr    = RES_A + 8'd1;
                mem.mem_wr_en   = !reset;
                mem.mem_wr_data = {3'b000, r_max};
                w_state_nxt     = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase
    end

    // Even byte offset is the MSB of the word.
    always_ff @(posedge clk) begin
        if (!reset && r_state == S_LOAD) begin
            if (r_cnt[0]) begin
                r_words[r_cnt[5:1]][7:0]  <= mem.mem_rd_data;
            end else begin
                r_words[r_cnt[5:1]][15:8] <= mem.mem_rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_min   <= 5'd16;
            r_max   <= '0;
            r_min_a <= '0;
            r_min_b <= '0;
            r_max_a <= '0;
            r_max_b <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_load_last) begin
                        r_j <= 5'd0;
                        r_k <= 5'd1;
                    end else begin
                        r_cnt <= r_cnt + 7'd1;
                    end
                end
                S_COMPARE: begin
                    // Strict compares: ties keep the earliest pair in (j,k) order.
                    if (w_dist < r_min) begin
                        r_min   <= w_dist;
                        r_min_a <= r_j;
                        r_min_b <= r_k;
                    end
                    if (w_dist > r_max) begin
                        r_max   <= w_dist;
                        r_max_a <= r_j;
                        r_max_b <= r_k;
                    end
                    if (!w_cmp_last) begin
                        if (r_k == LAST_K) begin
                            r_j <= r_j + 5'd1;
                            r_k <= r_j + 5'd2;
                        end else begin
                            r_k <= r_k + 5'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign min_dist  = r_min;
    assign max_dist  = r_max;
    assign min_idx_a = r_min_a;
    assign min_idx_b = r_min_b;
    assign max_idx_a = r_max_a;
    assign max_idx_b = r_max_b;

endmodule

// File: tb/tb_hamming_scan_engine.sv
// Scoreboarded bench: directed operand sets with hand-computed min/max pairs, a byte memory
// model, a write monitor, and a mid-run reset abort.
module tb_hamming_scan_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       done;
    logic [4:0] min_dist, max_dist, min_idx_a, min_idx_b, max_idx_a, max_idx_b;

    hamming_scan_engine_if mem_if ();

    hamming_scan_engine dut (
        .clk       (clk),
        .reset     (reset),
        .mem       (mem_if.master),
        .done      (done),
        .min_dist  (min_dist),
        .max_dist  (max_dist),
        .min_idx_a (min_idx_a),
        .min_idx_b (min_idx_b),
        .max_idx_a (max_idx_a),
        .max_idx_b (max_idx_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mn;
        int mx;
        int mna;
        int mnb;
        int mxa;
        int mxb;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mem [0:255];
    logic       ld_en = 1'b0;
    logic [7:0] ld_addr = 8'd0;
    logic [7:0] ld_dat = 8'd0;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         wr_cnt = 0;
    int         max_addr = 0;
    logic       done_q = 1'b0;

    assign mem_if.mem_rd_data = mem[mem_if.mem_addr];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Memory model, write monitor and cycle counter share one process so mem has a single writer.
    always @(posedge clk) begin
        if (reset) begin
            cyc      = 0;
            wr_cnt   = 0;
            max_addr = 0;
            if (ld_en) mem[ld_addr] = ld_dat;
        end else begin
            cyc++;
            if (int'(mem_if.mem_addr) > max_addr) max_addr = int'(mem_if.mem_addr);
            if (mem_if.mem_wr_en) begin
                chk("wr_addr", int'(mem_if.mem_addr), (wr_cnt == 0) ? 64 : 65);
                mem[mem_if.mem_addr] = mem_if.mem_wr_data;
                wr_cnt++;
            end
        end
    end

    // Scoreboard monitor: done rising is the DUT's result-valid event.
    always @(negedge clk) begin
        exp_t e;
        if (done && !done_q) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", cyc, 562);
                chk("min_dist", int'(min_dist), e.mn);
                chk("max_dist", int'(max_dist), e.mx);
                chk("min_idx_a", int'(min_idx_a), e.mna);
                chk("min_idx_b", int'(min_idx_b), e.mnb);
                chk("max_idx_a", int'(max_idx_a), e.mxa);
                chk("max_idx_b", int'(max_idx_b), e.mxb);
                chk("mem64", int'(mem[64]), e.mn);
                chk("mem65", int'(mem[65]), e.mx);
                chk("wr_count", wr_cnt, 2);
                chk("max_addr", max_addr, 65);
            end
        end
        done_q = done;
    end

    function automatic logic [15:0] gen_word(input int t, input int i);
        logic [15:0] w;
        w = 16'h0000;
        case (t)
            1: w = (i == 0) ? 16'h0000 : (i == 1) ? 16'hFFFF : 16'h00FF;
            2: w = 16'hFFFF >> (i % 16);
            3: begin
                if (i <= 2)       w = 16'h0000;
                else if (i <= 18) w = 16'h0001 << (i - 3);
                else              w = ~(16'h0001 << (i - 19));
            end
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    task automatic load_byte(input int a, input logic [7:0] d);
        ld_en   = 1'b1;
        ld_addr = 8'(a);
        ld_dat  = d;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic load_test(input int t, input logic [7:0] p64, input logic [7:0] p65);
        logic [15:0] w;
        reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            w = gen_word(t, i);
            load_byte(2 * i, w[15:8]);
            load_byte(2 * i + 1, w[7:0]);
        end
        load_byte(64, p64);
        load_byte(65, p65);
    endtask

    task automatic check_reset_state();
        chk("rst_done", int'(done), 0);
        chk("rst_min", int'(min_dist), 16);
        chk("rst_max", int'(max_dist), 0);
        chk("rst_addr", int'(mem_if.mem_addr), 0);
        chk("rst_wr_en", int'(mem_if.mem_wr_en), 0);
        chk("rst_wr_data", int'(mem_if.mem_wr_data), 0);
        chk("rst_idx", int'({min_idx_a, min_idx_b, max_idx_a, max_idx_b}), 0);
    endtask

    task automatic wait_done();
        int c;
        c = 0;
        while (!done && c < 1000) begin
            @(negedge clk);
            c++;
        end
        if (!done) chk("done_timeout", 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic run_test(input int t, input exp_t e);
        load_test(t, 8'hEE, 8'hEE);
        check_reset_state();
        sb.push_back(e);
        reset = 1'b0;
        wait_done();
    endtask

    initial begin
        exp_t e;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        @(negedge clk);

        e = '{mn: 0, mx: 0,  mna: 0, mnb: 1,  mxa: 0, mxb: 0};  run_test(0, e);
        e = '{mn: 0, mx: 16, mna: 2, mnb: 3,  mxa: 0, mxb: 1};  run_test(1, e);
        e = '{mn: 0, mx: 15, mna: 0, mnb: 16, mxa: 0, mxb: 15}; run_test(2, e);
        e = '{mn: 0, mx: 16, mna: 0, mnb: 1,  mxa: 3, mxb: 19}; run_test(3, e);

        // Abort at cycle 300, hold reset two cycles, then a clean rerun on the same data.
        load_test(2, 8'd16, 8'd0);
        reset = 1'b0;
        while (cyc < 300) @(negedge clk);
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("abort_done", int'(done), 0);
            chk("abort_mem64", int'(mem[64]), 16);
            chk("abort_mem65", int'(mem[65]), 0);
        end
        check_reset_state();
        e = '{mn: 0, mx: 15, mna: 0, mnb: 16, mxa: 0, mxb: 15};
        sb.push_back(e);
        reset = 1'b0;
        wait_done();

        reset = 1'b1;
        @(negedge clk);
        chk("done_cleared", int'(done), 0);
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hamming_scan_engine.md
Name: hamming_scan_engine

Overview:
Program-1 compute engine inside top_level. It is the responder to the bench's start/done handshake: it reads 32 16-bit operands from data_mem[0:63] and finds the minimum and maximum Hamming distance over all 496 unordered pairs. It writes the minimum to data_mem[64] and the maximum to data_mem[65], then raises done. It drives the data_mem port directly, as the only master while running.

Parameters:
NUM_WORDS, 32, number of 16-bit operands (legal 2..32)
BASE_ADDR, 0, byte address of first operand byte
RESULT_ADDR, 64, byte address for Min; Max goes to RESULT_ADDR+1

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; high = hold/clear, low = run (doubles as bench "start")
done  output  1  high when results are written; held until reset
mem_addr  output  8  data_mem byte address
mem_rd_data  input  8  data_mem read data, combinational from mem_addr in the same cycle
mem_wr_en  output  1  data_mem write strobe, written on the rising edge
mem_wr_data  output  8  data_mem write data
min_dist  output  5  final minimum distance
max_dist  output  5  final maximum distance
min_idx_a, min_idx_b  output  5 each  operand indices j<k of the min pair
max_idx_a, max_idx_b  output  5 each  operand indices j<k of the max pair

Behaviour:
- Reset (sampled at clk edge) sets state=LOAD, counters=0, done=0, mem_wr_en=0, mem_addr=BASE_ADDR, mem_wr_data=0, min_dist=16, max_dist=0, all idx=0.
- Reset mid-operation aborts immediately at the next edge with the same values as above. No write occurs in a cycle where reset is high.
- Word i = {byte[BASE_ADDR+2i], byte[BASE_ADDR+2i+1]}, with the first byte as MSB. Words are held in an internal 32x16 register buffer.
- LOAD: 2*NUM_WORDS cycles. mem_addr = BASE_ADDR+n for n = 0..2N-1, and mem_rd_data is captured each edge. mem_wr_en=0.
- COMPARE: one pair per cycle, (j,k) lexicographic, j = 0..N-2, k = j+1..N-1, giving N(N-1)/2 cycles (496 at default).
  - dist = popcount(word[j] ^ word[k]), 5 bits, range 0..16.
  - If dist < running_min: update min and (min_idx_a, min_idx_b) = (j,k).
  - If dist > running_max: update max and the max indices.
  - Strict compares: ties keep the earliest pair.
  - Both updates may occur on the same pair.
- WR_MIN: one cycle. mem_addr=RESULT_ADDR, mem_wr_data={3'b0,min}, mem_wr_en=1.
- WR_MAX: one cycle. mem_addr=RESULT_ADDR+1, mem_wr_data={3'b0,max}, mem_wr_en=1.
- DONE: done=1, mem_wr_en=0. The engine stays here until reset.
- Timing at default N: first edge with reset low is cycle 0. LOAD spans cycles 0-63, COMPARE 64-559, WR_MIN 560, WR_MAX 561. done is first high in cycle 562.
- Result ports (min_dist..max_idx_b) show the running values during COMPARE and are stable from WR_MIN onward.
- mem_wr_en is high only in WR_MIN/WR_MAX; no other memory location is ever written.
- Reasserting reset while done=1 clears done on the next edge. Deasserting it again starts a new full run that reloads memory, so no operand data is cached across runs.
- Starting values min=16/max=0 match the bench presets: all-16 data yields min=16, all-equal data yields max=0.

Test Plan:
- All 64 bytes 0x00 -> done at cycle 562; mem[64]=0, mem[65]=0; min pair (0,1), max pair (0,0) since it is never updated.
- Word0=0x0000, word1=0xFFFF, words 2..31=0x00FF -> min=0 pair (2,3); max=16 pair (0,1); mem[64]=0x00, mem[65]=0x10.
- Word i = 0xFFFF>>(i%16), i.e. bench random-style data loaded via $readmemb, repeated over 10 files -> mem[64]/[65] match the bench ham() reference every iteration (10/10 min, 10/10 max).
- Reset asserted at cycle 300 for 2 cycles, with mem[64] preset to 16 and mem[65] preset to 0 -> done stays 0, mem[64]/[65] unchanged through the abort; restart completes exactly 562 cycles after deassert with correct results.
- Write monitor on the memory port -> mem_wr_en high in exactly 2 cycles per run, addresses 64 then 65; no read/write outside 0..65.
- Tie check: words 0,1,2 identical, others pairwise distance >=1 -> min_idx=(0,1), not (0,2) or (1,2).
